// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: shares one SPI bus between the LTC2668 DAC and LTC2494 ADC
// requesters. Round-robin grant, owner chip select, one full-duplex mode-0 frame
// with a per-device SCK divisor, then a bus-idle gap before the next grant.
//
// Handshake: a requester raises req with tx stable and keeps both until its done
// pulse; done is high for exactly one cycle and rx is valid from that cycle on.
// A req that is low when the scheduler is IDLE is not granted.
module spi_bus_scheduler #(
    parameter int FRAME_BITS = 24,
    parameter int DAC_DIV    = 13,
    parameter int ADC_DIV    = 50,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int IDLE_GAP   = 4
) (
    input  logic                  clock_in,
    input  logic                  rst_n,
    input  logic                  dac_req,
    input  logic [FRAME_BITS-1:0] dac_tx,
    output logic [FRAME_BITS-1:0] dac_rx,
    output logic                  dac_done,
    input  logic                  adc_req,
    input  logic [FRAME_BITS-1:0] adc_tx,
    output logic [FRAME_BITS-1:0] adc_rx,
    output logic                  adc_done,
    output logic                  busy,
    output logic                  owner,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  dac_cs_n,
    output logic                  adc_cs_n,
    output logic [2:0]            dbg_state_o   // FSM state, IDLE encodes as 0
);
    localparam int MAX_A   = (DAC_DIV > ADC_DIV) ? DAC_DIV : ADC_DIV;
    localparam int MAX_B   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CNT = (MAX_C > IDLE_GAP) ? MAX_C : IDLE_GAP;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int BW      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;        // cycle count inside the current phase/period
    logic [BW-1:0]         bit_q, bit_d;        // SCK period index within the frame
    logic [CW-1:0]         div_q, div_d;        // SCK divisor of the current owner
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;      // last granted device, 1 = ADC
    logic [FRAME_BITS-1:0] shift_q, shift_d;    // outgoing frame, MSB on mosi
    logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;    // incoming miso bits
    logic [FRAME_BITS-1:0] dac_rx_q, dac_rx_d;
    logic [FRAME_BITS-1:0] adc_rx_q, adc_rx_d;
    logic                  dac_done_q, dac_done_d;
    logic                  adc_done_q, adc_done_d;

    logic                  grant_adc;
    logic [CW-1:0]         lo_len;
    logic                  cs_active;

    // On a tie the device not granted last wins.
    assign grant_adc = adc_req & (~dac_req | ~last_q);
    // Low phase takes the larger half so odd divisors stretch the low time.
    assign lo_len    = div_q - (div_q >> 1);
    assign cs_active = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);

    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign sck         = (state_q == S_SHIFT) && (cnt_q >= lo_len);
    assign mosi        = cs_active ? shift_q[FRAME_BITS-1] : 1'b0;
    assign dac_cs_n    = ~(cs_active & ~owner_q);
    assign adc_cs_n    = ~(cs_active & owner_q);
    assign dac_rx      = dac_rx_q;
    assign adc_rx      = adc_rx_q;
    assign dac_done    = dac_done_q;
    assign adc_done    = adc_done_q;
    assign dbg_state_o = state_q;

    // State register and datapath registers; async reset returns the bus to idle.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            shift_q    <= '0;
            rx_sh_q    <= '0;
            dac_rx_q   <= '0;
            adc_rx_q   <= '0;
            dac_done_q <= 1'b0;
            adc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            rx_sh_q    <= rx_sh_d;
            dac_rx_q   <= dac_rx_d;
            adc_rx_q   <= adc_rx_d;
            dac_done_q <= dac_done_d;
            adc_done_q <= adc_done_d;
        end
    end

    // Next-state logic: grant, chip-select setup, bit shifting, hold, idle gap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        div_d      = div_q;
        owner_d    = owner_q;
        last_d     = last_q;
        shift_d    = shift_q;
        rx_sh_d    = rx_sh_q;
        dac_rx_d   = dac_rx_q;
        adc_rx_d   = adc_rx_q;
        dac_done_d = 1'b0;
        adc_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dac_req || adc_req) begin
                    owner_d = grant_adc;
                    last_d  = grant_adc;
                    div_d   = grant_adc ? CW'(ADC_DIV) : CW'(DAC_DIV);
                    shift_d = grant_adc ? adc_tx : dac_tx;
                    rx_sh_d = '0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                // First high-phase cycle: sck has just risen, capture miso.
                if (cnt_q == lo_len) begin
                    rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], miso};
                end
                if (cnt_q == div_q - CW'(1)) begin
                    cnt_d = '0;
                    if (bit_q == BW'(FRAME_BITS - 1)) begin
                        state_d = S_HOLD;   // last bit stays on mosi through hold
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q << 1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                    if (owner_q) begin
                        adc_rx_d   = rx_sh_q;
                        adc_done_d = 1'b1;
                    end else begin
                        dac_rx_d   = rx_sh_q;
                        dac_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(IDLE_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
